spi_slave_word: RTL and testbench

Parametrised SPI slave that moves full words between an external SPI master and on-chip logic in the CLK domain. It oversamples SCLK, CS and MOSI through synchronisers and supports configurable word width and all four CPOL/CPHA modes. Words flow continuously while CS stays low. It provides a one-deep TX holding register and an RX output register, each with a valid/ready handshake, plus sticky overrun/underrun flags. It sits between the pad-level SPI pins and the core register/datapath logic, replacing the fixed-width shifter.

---
 rtl/spi_slave_word.sv | 204 ++++++++++++++++++++
 tb/tb_spi_slave_word.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_word.sv
// spi_slave_word: word-oriented SPI slave. SCLK/CS/MOSI are oversampled in the
// CLK domain, so every SCLK phase must span several CLK cycles.
// Handles all four CPOL/CPHA modes, back-to-back words while CS is held low,
// a one-deep TX holding register, an RX output register and sticky flags.
// Build option: define SPI_SLV_LSB_FIRST_EN to shift both directions LSB first.
module spi_slave_word #(
  parameter int WIDTH       = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SCLK,
  input  logic             CS,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             busy,
  output logic             overrun,
  output logic             underrun,
  input  logic             flag_clr
);

  localparam int   CW   = $clog2(WIDTH + 1);
  localparam logic POL  = (CPOL != 0);
  localparam logic PHA  = (CPHA != 0);
`ifdef SPI_SLV_LSB_FIRST_EN
  localparam logic LSB_FIRST = 1'b1;
`else
  localparam logic LSB_FIRST = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0]       tx_sh_q, tx_sh_d;
  logic                   skip_q, skip_d;
  logic [WIDTH-1:0]       hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [WIDTH-1:0]       rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   underrun_q, underrun_d;

  logic sclk_s, cs_s, mosi_s, sclk_chg, lead, trail;
  logic cs_fall, cs_rise, act, do_sample, do_shift, word_done, load;
  logic [WIDTH-1:0] rx_nxt, tx_adv;
  logic tx_bit, ovr_set, und_set;

  // Synchroniser chains and edge-detect history
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sclk_prev_d = sclk_s;
    sclk_chg    = sclk_s ^ sclk_prev_q;
    lead        = sclk_chg & (sclk_s != POL);
    trail       = sclk_chg & (sclk_s == POL);
  end

  // State register plus all datapath flops
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sclk_sync_q <= {SYNC_STAGES{POL}};
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= POL;
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      skip_q      <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      skip_q      <= skip_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
    end
  end

  // Next state follows the synchronised chip select
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!cs_s) state_d = ACTIVE;
      ACTIVE:  if (cs_s)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: transaction-level strobes decoded from state and edges
  always_comb begin
    cs_fall   = (state_q == IDLE) & ~cs_s;
    cs_rise   = (state_q == ACTIVE) & cs_s;
    act       = (state_q == ACTIVE) & ~cs_s;
    do_sample = act & (PHA ? trail : lead);
    do_shift  = act & (PHA ? lead : trail);
    word_done = do_sample & (cnt_q == CW'(WIDTH - 1));
    load      = cs_fall | word_done;
    busy      = (state_q == ACTIVE);
  end

  // Shift registers, bit counter, holding register, RX handshake and flags
  always_comb begin
    rx_nxt      = LSB_FIRST ? {mosi_s, rx_sh_q[WIDTH-1:1]} : {rx_sh_q[WIDTH-2:0], mosi_s};
    tx_adv      = LSB_FIRST ? {1'b0, tx_sh_q[WIDTH-1:1]} : {tx_sh_q[WIDTH-2:0], 1'b0};
    tx_bit      = LSB_FIRST ? tx_sh_q[0] : tx_sh_q[WIDTH-1];
    cnt_d       = cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    skip_d      = skip_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    ovr_set     = 1'b0;
    und_set     = 1'b0;
    if (cs_rise) begin
      // abandon any partial word; holding register is left alone
      cnt_d   = '0;
      rx_sh_d = '0;
      tx_sh_d = '0;
      skip_d  = 1'b0;
    end else begin
      if (do_sample) begin
        rx_sh_d = rx_nxt;
        cnt_d   = word_done ? '0 : cnt_q + 1'b1;
      end
      if (do_shift) begin
        if (skip_q) skip_d  = 1'b0;
        else        tx_sh_d = tx_adv;
      end
      if (load) begin
        if (hold_full_q) begin
          tx_sh_d     = hold_q;
          hold_full_d = 1'b0;
        end else begin
          tx_sh_d = '0;
          und_set = 1'b1;
        end
        // a freshly loaded bit 0 is already on MISO, so the next shift edge
        // must not advance; only the CPHA=0 start of a burst has no such edge
        skip_d = word_done | PHA;
      end
    end
    // capture only into an empty holding register (uses pre-cycle state)
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
    if (word_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = rx_nxt;
        rx_valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    overrun_d  = ovr_set | (overrun_q & ~flag_clr);
    underrun_d = und_set | (underrun_q & ~flag_clr);
  end

  assign MISO     = (state_q == ACTIVE) & tx_bit;
  assign tx_ready = ~hold_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_word.sv
// Directed bench: mode 0 / WIDTH=8 instance and mode 3 / WIDTH=16 instance.
module tb_spi_slave_word;
  localparam int HALF = 8;  // CLK cycles per SCLK phase

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  // mode 0, 8-bit instance
  logic       SCLK0 = 1'b0, CS0 = 1'b1, MOSI0 = 1'b0, MISO0;
  logic [7:0] tx_data0 = '0, rx_data0;
  logic       tx_valid0 = 1'b0, tx_ready0, rx_valid0, rx_ready0 = 1'b0;
  logic       busy0, ovr0, und0, flag_clr0 = 1'b0;

  // mode 3, 16-bit instance
  logic        SCLK3 = 1'b1, CS3 = 1'b1, MOSI3 = 1'b0, MISO3;
  logic [15:0] tx_data3 = '0, rx_data3;
  logic        tx_valid3 = 1'b0, tx_ready3, rx_valid3, rx_ready3 = 1'b0;
  logic        busy3, ovr3, und3, flag_clr3 = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  spi_slave_word #(.WIDTH(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) u_m0 (
    .CLK(CLK), .RST_N(RST_N), .SCLK(SCLK0), .CS(CS0), .MOSI(MOSI0), .MISO(MISO0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
    .busy(busy0), .overrun(ovr0), .underrun(und0), .flag_clr(flag_clr0));

  spi_slave_word #(.WIDTH(16), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) u_m3 (
    .CLK(CLK), .RST_N(RST_N), .SCLK(SCLK3), .CS(CS3), .MOSI(MOSI3), .MISO(MISO3),
    .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(tx_ready3),
    .rx_data(rx_data3), .rx_valid(rx_valid3), .rx_ready(rx_ready3),
    .busy(busy3), .overrun(ovr3), .underrun(und3), .flag_clr(flag_clr3));

  task automatic wait_clk(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0 master: MOSI set and MISO read while SCLK is low, rising edge samples
  task automatic xfer0(input logic [7:0] w, input int nbits, output logic [7:0] r);
    r = '0;
    for (int i = 0; i < nbits; i++) begin
      MOSI0 = w[7-i];
      wait_clk(HALF);
      r[7-i] = MISO0;
      SCLK0 = 1'b1;
      wait_clk(HALF);
      SCLK0 = 1'b0;
    end
  endtask

  // mode 3 master: falling edge shifts, MISO read just before the rising edge
  task automatic xfer3(input logic [15:0] w, input int nbits, output logic [15:0] r);
    r = '0;
    for (int i = 0; i < nbits; i++) begin
      SCLK3 = 1'b0;
      MOSI3 = w[15-i];
      wait_clk(HALF);
      r[15-i] = MISO3;
      SCLK3 = 1'b1;
      wait_clk(HALF);
    end
  endtask

  task automatic pulse_clr0();
    flag_clr0 = 1'b1; wait_clk(1); flag_clr0 = 1'b0;
  endtask

  task automatic consume0();
    rx_ready0 = 1'b1; wait_clk(1); rx_ready0 = 1'b0; wait_clk(1);
  endtask

  initial begin
    logic [7:0]  r8;
    logic [15:0] r16;

    // ---- reset state ----
    wait_clk(3);
    check("rst_miso",     MISO0,     0);
    check("rst_tx_ready", tx_ready0, 1);
    check("rst_rx_data",  rx_data0,  0);
    check("rst_rx_valid", rx_valid0, 0);
    check("rst_busy",     busy0,     0);
    check("rst_overrun",  ovr0,      0);
    check("rst_underrun", und0,      0);
    RST_N = 1'b1;
    wait_clk(3);

    // ---- mode 0 basic: send 0xA5, receive 0x3C ----
    tx_data0 = 8'hA5; tx_valid0 = 1'b1; wait_clk(1); tx_valid0 = 1'b0;
    check("m0_hold_full", tx_ready0, 0);
    CS0 = 1'b0; wait_clk(HALF);
    check("m0_busy",      busy0,     1);
    check("m0_load_rdy",  tx_ready0, 1);
    check("m0_load_und",  und0,      0);
    xfer0(8'h3C, 8, r8);
    check("m0_miso",      r8,        8'hA5);
    check("m0_rx_data",   rx_data0,  8'h3C);
    check("m0_rx_valid",  rx_valid0, 1);
    check("m0_overrun",   ovr0,      0);
    wait_clk(HALF); CS0 = 1'b1; wait_clk(6);
    check("m0_idle_busy", busy0,     0);
    check("m0_idle_miso", MISO0,     0);
    consume0();
    check("m0_consumed",  rx_valid0, 0);
    pulse_clr0();
    check("m0_clr_und",   und0,      0);

    // ---- back-to-back: 0x11/0x22 out, 0xF0/0x0F in ----
    rx_ready0 = 1'b1;
    tx_data0 = 8'h11; tx_valid0 = 1'b1; wait_clk(1); tx_valid0 = 1'b0;
    CS0 = 1'b0; wait_clk(HALF);
    check("b2b_rdy_after_load", tx_ready0, 1);
    tx_data0 = 8'h22; tx_valid0 = 1'b1; wait_clk(1); tx_valid0 = 1'b0;
    check("b2b_hold_full", tx_ready0, 0);
    xfer0(8'hF0, 8, r8);
    check("b2b_miso1",    r8,        8'h11);
    check("b2b_rx1",      rx_data0,  8'hF0);
    check("b2b_rdy_w2",   tx_ready0, 1);
    xfer0(8'h0F, 8, r8);
    check("b2b_miso2",    r8,        8'h22);
    check("b2b_rx2",      rx_data0,  8'h0F);
    check("b2b_rx_valid", rx_valid0, 0);
    check("b2b_overrun",  ovr0,      0);
    wait_clk(HALF); CS0 = 1'b1; wait_clk(6);
    rx_ready0 = 1'b0;
    pulse_clr0();

    // ---- overrun: 0x55 then 0xAA with rx_ready low ----
    CS0 = 1'b0; wait_clk(HALF);
    xfer0(8'h55, 8, r8);
    check("ovr_first_clean", ovr0, 0);
    xfer0(8'hAA, 8, r8);
    wait_clk(HALF); CS0 = 1'b1; wait_clk(6);
    check("ovr_rx_data",  rx_data0,  8'h55);
    check("ovr_rx_valid", rx_valid0, 1);
    check("ovr_flag",     ovr0,      1);
    wait_clk(10);
    check("ovr_sticky",   ovr0,      1);
    pulse_clr0();
    check("ovr_cleared",  ovr0,      0);
    consume0();
    check("ovr_consumed", rx_valid0, 0);

    // ---- underrun: no TX data, master sends 0x81 ----
    check("und_pre", und0, 0);
    CS0 = 1'b0; wait_clk(HALF);
    check("und_on_load", und0, 1);
    xfer0(8'h81, 8, r8);
    check("und_miso",    r8,       8'h00);
    check("und_rx_data", rx_data0, 8'h81);
    wait_clk(HALF); CS0 = 1'b1; wait_clk(6);
    consume0();
    pulse_clr0();

    // ---- CS abort after 5 bits, then full 0x9C ----
    CS0 = 1'b0; wait_clk(HALF);
    xfer0(8'hFF, 5, r8);
    wait_clk(HALF); CS0 = 1'b1; wait_clk(10);
    check("abort_no_valid", rx_valid0, 0);
    check("abort_rx_keep",  rx_data0,  8'h81);
    CS0 = 1'b0; wait_clk(HALF);
    xfer0(8'h9C, 8, r8);
    check("abort_next_rx",    rx_data0,  8'h9C);
    check("abort_next_valid", rx_valid0, 1);
    wait_clk(HALF); CS0 = 1'b1; wait_clk(6);

    // ---- mode 3, 16-bit: 0xBEEF out, 0x1234 in ----
    tx_data3 = 16'hBEEF; tx_valid3 = 1'b1; wait_clk(1); tx_valid3 = 1'b0;
    check("m3_hold_full", tx_ready3, 0);
    CS3 = 1'b0; wait_clk(HALF);
    check("m3_busy", busy3, 1);
    xfer3(16'h1234, 16, r16);
    check("m3_miso",     r16,       16'hBEEF);
    check("m3_rx_data",  rx_data3,  16'h1234);
    check("m3_rx_valid", rx_valid3, 1);
    CS3 = 1'b1; wait_clk(HALF);

    // ---- mode 3: reset pulse mid-word ----
    tx_data3 = 16'hCAFE; tx_valid3 = 1'b1; wait_clk(1); tx_valid3 = 1'b0;
    CS3 = 1'b0; wait_clk(HALF);
    xfer3(16'hFFFF, 6, r16);
    check("m3_pre_rst_busy", busy3, 1);
    RST_N = 1'b0; #1;
    check("m3_rst_miso",     MISO3,     0);
    check("m3_rst_tx_ready", tx_ready3, 1);
    check("m3_rst_rx_data",  rx_data3,  0);
    check("m3_rst_rx_valid", rx_valid3, 0);
    check("m3_rst_busy",     busy3,     0);
    check("m3_rst_overrun",  ovr3,      0);
    check("m3_rst_underrun", und3,      0);
    CS3 = 1'b1; SCLK3 = 1'b1;
    wait_clk(2);
    RST_N = 1'b1;
    wait_clk(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
